tt_um_chrishtet_lif: RTL and testbench
======================================

# tt_um_chrishtet_lif

Single leaky integrate-and-fire (LIF) neuron for a TinyTapeout tile. Each enabled clock it leaks its 8-bit membrane potential by a programmable right-shift, adds the 8-bit input current from `ui_in`, and fires a one-cycle spike when the potential reaches a programmable threshold. Threshold, leak shift and refractory period are written through `uio_in`. The spike and the membrane potential are presented on `uo_out`.

## Interface
- No parameters. Reset defaults are fixed constants: THRESH_DEF=200, LEAK_DEF=1, REFR_DEF=0.
- `clk`: input, 1 bit. The single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `ena`: input, 1 bit. Tile enable. While low, all state is frozen.
- `ui_in`: input, 8 bits. Input current (unsigned). In a config-write cycle it carries config data instead.
- `uio_in`: input, 8 bits.
  - [7]: cfg_we.
  - [6:5]: cfg_addr (0 = threshold, 1 = leak shift, 2 = refractory, 3 = ignored).
  - [4:0]: unused.
- `uo_out`: output, 8 bits. [7] = spike; [6:0] = membrane[7:1].
- `uio_out`: output, 8 bits. Constant 0.
- `uio_oe`: output, 8 bits. Constant 0; all uio pins are inputs.

## Operation
- **State registers**
  - mem: 8 bits.
  - thresh: 8 bits.
  - leak_k: 3 bits.
  - refr_len: 8 bits.
  - refr_cnt: 8 bits.
  - spike: 1 bit.
- **Reset:** mem=0, spike=0, refr_cnt=0, thresh=200, leak_k=1, refr_len=0. Therefore uo_out=0x00.
- **ena=0:** every register holds its value.
- **Config cycle (ena=1, cfg_we=1):**
  - Write the register selected by cfg_addr:
    - addr 0: thresh ← ui_in.
    - addr 1: leak_k ← ui_in[2:0].
    - addr 2: refr_len ← ui_in.
    - addr 3: no write.
  - mem, refr_cnt and spike hold. No integration occurs in this cycle.
- **Refractory cycle (ena=1, cfg_we=0, refr_cnt≠0):** refr_cnt decrements by 1, mem stays 0, spike=0, and ui_in is ignored.
- **Integrate cycle (ena=1, cfg_we=0, refr_cnt=0):**
  - Leak: leak = (leak_k==0) ? 0 : mem >> leak_k. leak_k=0 means no leak.
  - Sum: sum = mem − leak + ui_in, computed in 9 bits. mem_next = min(sum, 255) (saturates).
  - If mem_next ≥ thresh: spike←1, mem←0, refr_cnt←refr_len.
  - Otherwise: spike←0, mem←mem_next.
- **Boundary cases**
  - thresh=0: spikes on every integrate cycle.
  - thresh=255 with saturation: fires once the sum reaches 255.
  - refr_len=0: integration resumes on the cycle immediately after the spike.
- **Reset mid-refractory or mid-spike:** immediately returns all registers to their reset values.

## Timing
- All outputs are registered. No combinational path exists from any input to uo_out.
- Latency is one cycle: the effect of ui_in sampled at edge N is visible on uo_out after edge N.
- The spike is high for exactly one cycle per firing.
- A spike is followed by refr_len refractory cycles, then integration resumes.
- A config write takes effect for the next integrate cycle.
- Cycles with ena=0 are not counted; the refractory count freezes along with everything else.

## Structure
- Package `lif_pkg`:
  - cfg address constants ADDR_THRESH=0, ADDR_LEAK=1, ADDR_REFR=2.
  - reset default constants.
  - widths MEM_W=8, LEAK_W=3.
- Sub-module `lif_core` holds mem, spike, refr_cnt and the leak/add/saturate/compare datapath. It takes current, thresh, leak_k, refr_len, step_en and hold as inputs.
- The top level holds the config registers, decodes uio_in, and packs uo_out.

## Test plan
- **Reset and defaults:** assert rst_n=0 asynchronously mid-cycle → uo_out=0x00 immediately, uio_oe=0x00, uio_out=0x00.
- **Default integration:** ui_in=100, defaults → mem sequence 100, 150, 175, 188, 194, 197, 199. On the 8th edge, spike=1 and mem=0 (uo_out=0x80). The next cycle gives mem=100 and spike=0.
- **Saturation:** ui_in=255 with thresh set to 255 → mem saturates to 255 on the first edge and spikes immediately. Then write thresh=200; ui_in=255 → spike every cycle.
- **Refractory:** write refr_len=3, ui_in=255 → spike, then exactly 3 cycles with spike=0 and uo_out[6:0]=0, then the next spike.
- **No leak:** write leak_k=0, thresh=50, ui_in=10 → mem 10, 20, 30, 40; on the 5th edge, spike.
- **ena gating:** drop ena during integration → uo_out is unchanged for any number of cycles and resumes from the held state when ena returns.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared constants for the leaky integrate-and-fire neuron tile.
//   - datapath widths (MEM_W, LEAK_W)
//   - configuration register addresses carried on uio_in[6:5]
//   - reset defaults for the configuration registers
package lif_pkg;

  localparam int MEM_W  = 8;
  localparam int LEAK_W = 3;

  localparam logic [1:0] ADDR_THRESH = 2'd0;
  localparam logic [1:0] ADDR_LEAK   = 2'd1;
  localparam logic [1:0] ADDR_REFR   = 2'd2;

  localparam logic [MEM_W-1:0]  THRESH_DEF = 8'd200;
  localparam logic [LEAK_W-1:0] LEAK_DEF   = 3'd1;
  localparam logic [MEM_W-1:0]  REFR_DEF   = 8'd0;

  // Saturating 8-bit result of a 9-bit intermediate sum.
  function automatic logic [MEM_W-1:0] sat8(input logic [MEM_W:0] value);
    return value[MEM_W] ? {MEM_W{1'b1}} : value[MEM_W-1:0];
  endfunction

endpackage

// File: rtl/lif_core.sv
// lif_core: membrane state and datapath of a single LIF neuron.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   step_en          - tile enable; when low every register is frozen
//   hold             - config cycle in progress; state holds, no integration
//   current          - input current added on integrate cycles
//   thresh           - firing threshold
//   leak_k           - leak right-shift amount (0 = no leak)
//   refr_len         - refractory cycles loaded after each spike
//   mem              - membrane potential
//   spike            - one-cycle firing flag
module lif_core
  import lif_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic              hold,
  input  logic [MEM_W-1:0]  current,
  input  logic [MEM_W-1:0]  thresh,
  input  logic [LEAK_W-1:0] leak_k,
  input  logic [MEM_W-1:0]  refr_len,
  output logic [MEM_W-1:0]  mem,
  output logic              spike
);

  logic [MEM_W-1:0] refr_cnt;
  logic [MEM_W-1:0] leak;
  logic [MEM_W:0]   sum;
  logic [MEM_W-1:0] mem_next;
  logic             fire;

  // mem >> leak_k never exceeds mem, so the subtraction cannot underflow
  // and the 9-bit sum only needs saturation at the top.
  always_comb begin
    leak     = (leak_k == '0) ? '0 : (mem >> leak_k);
    sum      = {1'b0, mem} - {1'b0, leak} + {1'b0, current};
    mem_next = sat8(sum);
    fire     = (mem_next >= thresh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      spike    <= 1'b0;
      refr_cnt <= '0;
    end else if (step_en && !hold) begin
      if (refr_cnt != '0) begin
        refr_cnt <= refr_cnt - 1'b1;
        mem      <= '0;
        spike    <= 1'b0;
      end else if (fire) begin
        spike    <= 1'b1;
        mem      <= '0;
        refr_cnt <= refr_len;
      end else begin
        spike    <= 1'b0;
        mem      <= mem_next;
      end
    end
  end

endmodule

// File: rtl/tt_um_chrishtet_lif.sv
// tt_um_chrishtet_lif: TinyTapeout wrapper around one LIF neuron.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   ena        - tile enable; freezes all state while low
//   ui_in      - input current, or config data when uio_in[7] is set
//   uio_in     - [7] cfg_we, [6:5] cfg_addr, [4:0] unused
//   uo_out     - [7] spike, [6:0] membrane[7:1]
//   uio_out    - constant 0
//   uio_oe     - constant 0 (all uio pins are inputs)
module tt_um_chrishtet_lif
  import lif_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [MEM_W-1:0]  thresh;
  logic [LEAK_W-1:0] leak_k;
  logic [MEM_W-1:0]  refr_len;
  logic [MEM_W-1:0]  mem;
  logic              spike;
  logic              unused_bits;

  assign cfg_we   = uio_in[7];
  assign cfg_addr = uio_in[6:5];

  // Address 3 is decoded as a no-op write; the cycle still suppresses
  // integration because cfg_we alone puts the core into hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh   <= THRESH_DEF;
      leak_k   <= LEAK_DEF;
      refr_len <= REFR_DEF;
    end else if (ena && cfg_we) begin
      case (cfg_addr)
        ADDR_THRESH: thresh   <= ui_in;
        ADDR_LEAK:   leak_k   <= ui_in[LEAK_W-1:0];
        ADDR_REFR:   refr_len <= ui_in;
        default:     ;
      endcase
    end
  end

  lif_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (ena),
    .hold     (cfg_we),
    .current  (ui_in),
    .thresh   (thresh),
    .leak_k   (leak_k),
    .refr_len (refr_len),
    .mem      (mem),
    .spike    (spike)
  );

  assign uo_out  = {spike, mem[MEM_W-1:1]};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign unused_bits = &{1'b0, uio_in[4:0], mem[0]};

endmodule

// File: tb/tb_tt_um_chrishtet_lif.sv
// tb_tt_um_chrishtet_lif: directed-vector bench for the LIF neuron tile.
module tb_tt_um_chrishtet_lif;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vec_count;
  int miscompare_count;

  tt_um_chrishtet_lif dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, clock once, settle 1ns past the edge.
  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio,
                               input logic en);
    ui_in  = ui;
    uio_in = uio;
    ena    = en;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic doReset();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b0;
    #3;
    rst_n  = 1'b1;
  endtask

  logic [7:0] dflt_exp [9];
  logic [7:0] nl_exp [5];

  initial begin
    vec_count        = 0;
    miscompare_count = 0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(posedge clk);
    #1;

    // Default integration: 100,150,175,188,194,197,199, spike, 100.
    doReset();
    checkOutput("reset_uo", uo_out, 8'h00);
    checkOutput("reset_oe", uio_oe, 8'h00);
    checkOutput("reset_out", uio_out, 8'h00);
    dflt_exp = '{8'h32, 8'h4B, 8'h57, 8'h5E, 8'h61, 8'h62, 8'h63, 8'h80, 8'h32};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'd100, 8'h00, 1'b1);
      checkOutput($sformatf("dflt_%0d", i), uo_out, dflt_exp[i]);
    end

    // Asynchronous reset mid-cycle with nonzero state.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", uo_out, 8'h00);
    rst_n = 1'b1;

    // Saturation at thresh=255, then thresh=200 spikes every cycle.
    doReset();
    applyStimulus(8'd255, 8'h80, 1'b1);
    checkOutput("cfg_thr255", uo_out, 8'h00);
    applyStimulus(8'd255, 8'h00, 1'b1);
    checkOutput("sat_spike", uo_out, 8'h80);
    applyStimulus(8'd200, 8'h80, 1'b1);
    checkOutput("cfg_hold_spike", uo_out, 8'h80);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'd255, 8'h00, 1'b1);
      checkOutput($sformatf("sat_rep_%0d", i), uo_out, 8'h80);
    end

    // Refractory of 3 cycles between spikes.
    doReset();
    applyStimulus(8'd3, 8'hC0, 1'b1);
    applyStimulus(8'd255, 8'h00, 1'b1);
    checkOutput("refr_spike0", uo_out, 8'h80);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'd255, 8'h00, 1'b1);
      checkOutput($sformatf("refr_quiet_%0d", i), uo_out, 8'h00);
    end
    applyStimulus(8'd255, 8'h00, 1'b1);
    checkOutput("refr_spike1", uo_out, 8'h80);

    // No leak, thresh=50, current 10.
    doReset();
    applyStimulus(8'd0, 8'hA0, 1'b1);
    applyStimulus(8'd50, 8'h80, 1'b1);
    nl_exp = '{8'h05, 8'h0A, 8'h0F, 8'h14, 8'h80};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'd10, 8'h00, 1'b1);
      checkOutput($sformatf("noleak_%0d", i), uo_out, nl_exp[i]);
    end

    // thresh=0 fires on every integrate cycle, even with zero current.
    doReset();
    applyStimulus(8'd0, 8'h80, 1'b1);
    applyStimulus(8'd0, 8'h00, 1'b1);
    checkOutput("thr0_a", uo_out, 8'h80);
    applyStimulus(8'd0, 8'h00, 1'b1);
    checkOutput("thr0_b", uo_out, 8'h80);

    // Address 3 writes nothing: threshold stays at its default.
    doReset();
    applyStimulus(8'd0, 8'hE0, 1'b1);
    applyStimulus(8'd100, 8'h00, 1'b1);
    checkOutput("addr3_nowrite", uo_out, 8'h32);

    // ena gating: freeze at 150, resume to 175.
    doReset();
    applyStimulus(8'd100, 8'h00, 1'b1);
    applyStimulus(8'd100, 8'h00, 1'b1);
    checkOutput("ena_pre", uo_out, 8'h4B);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'd100, (i == 2) ? 8'h80 : 8'h00, 1'b0);
      checkOutput($sformatf("ena_hold_%0d", i), uo_out, 8'h4B);
    end
    applyStimulus(8'd100, 8'h00, 1'b1);
    checkOutput("ena_resume", uo_out, 8'h57);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
